// File: rtl/fx2_rot_sched.sv
// fx2_rot_sched: round-robin issue scheduler for the FX2 halfword rotate-immediate datapath.
// Optional synchronous flush port enabled by defining FX2_ROT_FLUSH_EN.
module fx2_rot_sched #(
    parameter int LATENCY = 4,
    parameter int TAG_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [0:127]     req0_ra,
    input  logic [0:6]       req0_imm7,
    input  logic [0:TAG_W-1] req0_rt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [0:127]     req1_ra,
    input  logic [0:6]       req1_imm7,
    input  logic [0:TAG_W-1] req1_rt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:127]     out_result,
    output logic [0:TAG_W-1] out_rt,
    output logic             out_src,
    output logic             busy
`ifdef FX2_ROT_FLUSH_EN
    ,
    input  logic             flush
`endif
);
    logic [LATENCY:1] v;
    logic [LATENCY:1] src;
    logic [0:127]     data [1:LATENCY];
    logic [0:TAG_W-1] tag  [1:LATENCY];
    logic             last_grant, stall, adv, g0, g1, grant;
    logic [0:127]     sel_ra, rot;
    logic [0:TAG_W-1] sel_rt;
    logic [3:0]       s;
    logic             unused_imm;

    assign unused_imm = ^{req0_imm7[0:2], req1_imm7[0:2]};
    assign stall = v[LATENCY] & ~out_ready;
`ifdef FX2_ROT_FLUSH_EN
    assign adv = ~stall & ~flush;
`else
    assign adv = ~stall;
`endif
    assign g0 = adv & req0_valid & (~req1_valid | last_grant);
    assign g1 = adv & req1_valid & (~req0_valid | ~last_grant);
    assign grant = g0 | g1;
    assign req0_ready = g0;
    assign req1_ready = g1;

    assign sel_ra = g1 ? req1_ra : req0_ra;
    assign sel_rt = g1 ? req1_rt : req0_rt;
    assign s      = g1 ? req1_imm7[3:6] : req0_imm7[3:6];

    // Doubling the halfword turns the rotate into a plain left shift.
    for (genvar h = 0; h < 8; h++) begin : g_hw
        logic [31:0] dd;
        assign dd = {2{sel_ra[16*h +: 16]}} << s;
        assign rot[16*h +: 16] = dd[31:16];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v          <= '0;
            src        <= '0;
            last_grant <= 1'b1;
            for (int i = 1; i <= LATENCY; i++) begin
                data[i] <= '0;
                tag[i]  <= '0;
            end
        end
`ifdef FX2_ROT_FLUSH_EN
        else if (flush) begin
            v   <= '0;
            src <= '0;
            for (int i = 1; i <= LATENCY; i++) begin
                data[i] <= '0;
                tag[i]  <= '0;
            end
        end
`endif
        else if (~stall) begin
            for (int i = LATENCY; i >= 2; i--) begin
                v[i]    <= v[i-1];
                src[i]  <= src[i-1];
                data[i] <= data[i-1];
                tag[i]  <= tag[i-1];
            end
            v[1]    <= grant;
            src[1]  <= g1;
            data[1] <= grant ? rot : '0;
            tag[1]  <= grant ? sel_rt : '0;
            if (grant) last_grant <= g1;
        end
    end

    assign out_valid  = v[LATENCY];
    assign out_result = v[LATENCY] ? data[LATENCY] : '0;
    assign out_rt     = v[LATENCY] ? tag[LATENCY] : '0;
    assign out_src    = v[LATENCY] & src[LATENCY];
    assign busy       = |v;
endmodule

// File: tb/tb_fx2_rot_sched.sv
// tb_fx2_rot_sched: directed table-driven bench for fx2_rot_sched (LATENCY=4, TAG_W=7).
module tb_fx2_rot_sched;
    logic         clk = 0, rst = 1;
    logic         req0_valid = 0, req1_valid = 0, out_ready = 1;
    logic         req0_ready, req1_ready, out_valid, out_src, busy;
    logic [0:127] req0_ra = '0, req1_ra = '0, out_result;
    logic [0:6]   req0_imm7 = '0, req1_imm7 = '0;
    logic [0:6]   req0_rt = '0, req1_rt = '0, out_rt;
`ifdef FX2_ROT_FLUSH_EN
    logic         flush = 0;
`endif
    int errors = 0, checks = 0;

    fx2_rot_sched #(.LATENCY(4), .TAG_W(7)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ra(req0_ra),
        .req0_imm7(req0_imm7), .req0_rt(req0_rt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ra(req1_ra),
        .req1_imm7(req1_imm7), .req1_rt(req1_rt),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rt(out_rt), .out_src(out_src), .busy(busy)
`ifdef FX2_ROT_FLUSH_EN
        , .flush(flush)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           sel;
        logic [127:0] ra;
        logic [6:0]   imm;
        logic [6:0]   rt;
        logic [127:0] res;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] RA_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] RA_B = 128'hFFFF_0000_AAAA_5555_1111_2222_4444_8888;
    localparam logic [127:0] RA_P = {8{16'h8000}};
    localparam logic [127:0] RS_P = {8{16'h0001}};

    initial begin
        vecs[0] = '{0, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 7'h01, 7'd5,
                    128'h0001_0000_0000_0000_0000_0000_0000_0000};
        vecs[1] = '{1, 128'h0001_1234_8000_FFFF_0000_A5A5_0F0F_C003, 7'h7F, 7'd9,
                    128'h8000_091A_4000_FFFF_0000_D2D2_8787_E001};
        vecs[2] = '{1, RA_A, 7'h10, 7'h7F, RA_A};
        vecs[3] = '{0, {8{16'h1234}}, 7'h74, 7'd42, {8{16'h2341}}};
        vecs[4] = '{1, {8{16'hABCD}}, 7'h08, 7'd3, {8{16'hCDAB}}};

        repeat (2) step;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_rt", out_rt, 0);
        chk("rst_out_src", out_src, 0);
        rst = 0;
        step;

        foreach (vecs[i]) begin
            if (vecs[i].sel) begin
                req1_valid = 1; req1_ra = vecs[i].ra; req1_imm7 = vecs[i].imm; req1_rt = vecs[i].rt;
            end else begin
                req0_valid = 1; req0_ra = vecs[i].ra; req0_imm7 = vecs[i].imm; req0_rt = vecs[i].rt;
            end
            #1;
            chk($sformatf("v%0d_ready", i), vecs[i].sel ? req1_ready : req0_ready, 1);
            step;
            req0_valid = 0; req1_valid = 0;
            repeat (2) step;
            chk($sformatf("v%0d_early", i), out_valid, 0);
            step;
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_result", i), out_result, vecs[i].res);
            chk($sformatf("v%0d_rt", i), out_rt, vecs[i].rt);
            chk($sformatf("v%0d_src", i), out_src, vecs[i].sel);
            step;
            chk($sformatf("v%0d_drain", i), busy, 0);
        end

        // Mid-stream reset with three ops in flight; last grant was to req1, leave it at req0.
        req0_valid = 1; req0_ra = RA_A; req0_imm7 = 0;
        repeat (3) step;
        req0_valid = 0;
        chk("pre_rst_busy", busy, 1);
        rst = 1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_result", out_result, 0);
        repeat (2) step;
        rst = 0;
        step;

        // Both requesters valid four cycles in a row: alternating grants starting at req0.
        req0_ra = RA_A; req1_ra = RA_B; req0_imm7 = 7'h10; req1_imm7 = 7'h00;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1; req1_valid = 1; req0_rt = 7'(i); req1_rt = 7'(16 + i);
            #1;
            chk($sformatf("rr%0d_ready0", i), req0_ready, (i % 2) == 0);
            chk($sformatf("rr%0d_ready1", i), req1_ready, (i % 2) == 1);
            step;
        end
        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr%0d_out_valid", i), out_valid, 1);
            chk($sformatf("rr%0d_out_src", i), out_src, i % 2);
            chk($sformatf("rr%0d_out_rt", i), out_rt, (i % 2) ? 16 + i : i);
            chk($sformatf("rr%0d_out_result", i), out_result, (i % 2) ? RA_B : RA_A);
            step;
        end
        chk("rr_drain", busy, 0);

        // Full pipe held off by the consumer for six cycles.
        out_ready = 0; req0_ra = RA_P; req0_imm7 = 7'h01;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1; req0_rt = 7'(10 + i);
            #1;
            chk($sformatf("fill%0d_ready", i), req0_ready, 1);
            step;
        end
        req1_valid = 1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("stall%0d_ready0", i), req0_ready, 0);
            chk($sformatf("stall%0d_ready1", i), req1_ready, 0);
            chk($sformatf("stall%0d_valid", i), out_valid, 1);
            chk($sformatf("stall%0d_rt", i), out_rt, 10);
            chk($sformatf("stall%0d_result", i), out_result, RS_P);
            step;
        end
        out_ready = 1; req0_valid = 0; req1_valid = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rel%0d_valid", i), out_valid, 1);
            chk($sformatf("rel%0d_rt", i), out_rt, 10 + i);
            step;
        end
        chk("rel_done_valid", out_valid, 0);
        chk("rel_done_busy", busy, 0);

`ifdef FX2_ROT_FLUSH_EN
        req0_valid = 1; req0_ra = RA_A; req0_imm7 = 0; req0_rt = 7'd1;
        repeat (3) step;
        flush = 1; req1_valid = 1;
        #1;
        chk("flush_ready0", req0_ready, 0);
        chk("flush_ready1", req1_ready, 0);
        step;
        flush = 0; req0_valid = 0; req1_valid = 0;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        req1_valid = 1; req1_ra = RA_B; req1_imm7 = 0; req1_rt = 7'd77;
        #1;
        chk("postflush_ready1", req1_ready, 1);
        step;
        req1_valid = 0;
        repeat (3) step;
        chk("postflush_valid", out_valid, 1);
        chk("postflush_rt", out_rt, 77);
        chk("postflush_src", out_src, 1);
        chk("postflush_result", out_result, RA_B);
        step;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
